// File: rtl/sifh_seq_pkg.sv
// sifh_seq_pkg: shared types and defaults for the SiFH frame sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default parameter constants, pass encoding, sequencer state
// enum and a counter-width helper that never returns zero.
package sifh_seq_pkg;

   localparam int SEQ_NP           = 10;
   localparam int SEQ_DATA_NUM     = 2;
   localparam int SEQ_PIXEL_NUM    = 4;
   localparam int SEQ_ACQ_NUM      = 3;
   localparam int SEQ_CLR_CYCLES   = 4;
   localparam int SEQ_DRAIN_CYCLES = 3;

   localparam logic PASS_COARSE = 1'b0;
   localparam logic PASS_FINE   = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_CALC  = 3'd4,
      S_DONE  = 3'd5
   } seq_state_t;

   // Width of a counter holding 0..n-1; a single-value counter still gets
   // one bit so ports and registers never collapse to zero width.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sifh_beat_counter.sv
// sifh_beat_counter: nested input/pixel/acquisition counter for histogram beats.
// Latency: counters update on the edge after adv; last/pixel are decoded from the current count.
// Backpressure: none; the counter advances only when adv is high, otherwise holds.
// Ports: clk/res (async active-high), clr (sync clear to 0, wins over adv),
// adv (count one beat), pixel (current pixel index), last (count sits on the
// final beat of the acquisition set).
module sifh_beat_counter
   import sifh_seq_pkg::*;
#(
   parameter int DATA_NUM  = SEQ_DATA_NUM,
   parameter int PIXEL_NUM = SEQ_PIXEL_NUM,
   parameter int ACQ_NUM   = SEQ_ACQ_NUM,
   parameter int PW        = cnt_w(PIXEL_NUM)
)(
   input  logic          clk,
   input  logic          res,
   input  logic          clr,
   input  logic          adv,
   output logic [PW-1:0] pixel,
   output logic          last
);

   localparam int IW = cnt_w(DATA_NUM);
   localparam int AW = cnt_w(ACQ_NUM);

   localparam logic [IW-1:0] IN_MAX  = IW'(DATA_NUM - 1);
   localparam logic [PW-1:0] PIX_MAX = PW'(PIXEL_NUM - 1);
   localparam logic [AW-1:0] ACQ_MAX = AW'(ACQ_NUM - 1);

   logic [IW-1:0] input_cnt_q, input_cnt_d;
   logic [PW-1:0] pixel_cnt_q, pixel_cnt_d;
   logic [AW-1:0] acq_cnt_q,   acq_cnt_d;

   always_comb begin
      input_cnt_d = input_cnt_q;
      pixel_cnt_d = pixel_cnt_q;
      acq_cnt_d   = acq_cnt_q;
      if (clr) begin
         input_cnt_d = '0;
         pixel_cnt_d = '0;
         acq_cnt_d   = '0;
      end else if (adv) begin
         // Each level wraps at its maximum and carries into the next; the
         // final beat wraps everything back to zero for the next pass.
         if (input_cnt_q == IN_MAX) begin
            input_cnt_d = '0;
            if (pixel_cnt_q == PIX_MAX) begin
               pixel_cnt_d = '0;
               if (acq_cnt_q == ACQ_MAX) begin
                  acq_cnt_d = '0;
               end else begin
                  acq_cnt_d = acq_cnt_q + AW'(1);
               end
            end else begin
               pixel_cnt_d = pixel_cnt_q + PW'(1);
            end
         end else begin
            input_cnt_d = input_cnt_q + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         input_cnt_q <= '0;
         pixel_cnt_q <= '0;
         acq_cnt_q   <= '0;
      end else begin
         input_cnt_q <= input_cnt_d;
         pixel_cnt_q <= pixel_cnt_d;
         acq_cnt_q   <= acq_cnt_d;
      end
   end

   assign pixel = pixel_cnt_q;
   assign last  = (input_cnt_q == IN_MAX) && (pixel_cnt_q == PIX_MAX) && (acq_cnt_q == ACQ_MAX);

endmodule

// File: rtl/sifh_frame_sequencer.sv
// sifh_frame_sequencer: sequences the two-pass (coarse/fine) SiFH histogram build for one RAM bank.
// Latency: accepted timestamp appears on bld_* one cycle later; clear/drain/calc phases add fixed gaps.
// Backpressure: in_ready only in RUN; frame_valid holds in DONE until frame_ready.
// Ports: clk/res (async active-high); enable starts a frame (IDLE/DONE only);
// in_valid/in_data/in_ready is the TDC timestamp handshake; bld_wr_en/bld_data/
// bld_pixel/bld_pass are the registered builder write beat; bld_clear and
// bld_calc drive builder housekeeping; frame_valid/frame_ready hand the peak
// results downstream; busy is high whenever the sequencer is not idle.
module sifh_frame_sequencer
   import sifh_seq_pkg::*;
#(
   parameter int NP           = SEQ_NP,
   parameter int DATA_NUM     = SEQ_DATA_NUM,
   parameter int PIXEL_NUM    = SEQ_PIXEL_NUM,
   parameter int ACQ_NUM      = SEQ_ACQ_NUM,
   parameter int CLR_CYCLES   = SEQ_CLR_CYCLES,
   parameter int DRAIN_CYCLES = SEQ_DRAIN_CYCLES,
   // A single-pixel bank still gets a 1-bit pixel index.
   parameter int PW           = cnt_w(PIXEL_NUM)
)(
   input  logic          clk,
   input  logic          res,
   input  logic          enable,
   input  logic          in_valid,
   input  logic [NP-1:0] in_data,
   output logic          in_ready,
   output logic          bld_wr_en,
   output logic [NP-1:0] bld_data,
   output logic [PW-1:0] bld_pixel,
   output logic          bld_pass,
   output logic          bld_clear,
   output logic          bld_calc,
   output logic          frame_valid,
   input  logic          frame_ready,
   output logic          busy
);

   // One wait counter serves both CLEAR and DRAIN; it is zero on entry to either.
   localparam int WAIT_MAX = (CLR_CYCLES > DRAIN_CYCLES) ? CLR_CYCLES : DRAIN_CYCLES;
   localparam int WW       = cnt_w(WAIT_MAX);
   localparam logic [WW-1:0] CLR_LAST   = WW'(CLR_CYCLES - 1);
   localparam logic [WW-1:0] DRAIN_LAST = WW'(DRAIN_CYCLES - 1);

   seq_state_t    state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          pass_q, pass_d;
   logic          bld_wr_en_q, bld_wr_en_d;
   logic [NP-1:0] bld_data_q, bld_data_d;
   logic [PW-1:0] bld_pixel_q, bld_pixel_d;
   logic          bld_clear_q, bld_clear_d;
   logic          bld_calc_q, bld_calc_d;
   logic          frame_valid_q, frame_valid_d;

   logic          beat_acc;
   logic [PW-1:0] cnt_pixel;
   logic          cnt_last;

   assign beat_acc = (state_q == S_RUN) && in_valid;

   sifh_beat_counter #(
      .DATA_NUM  (DATA_NUM),
      .PIXEL_NUM (PIXEL_NUM),
      .ACQ_NUM   (ACQ_NUM),
      .PW        (PW)
   ) u_beat_counter (
      .clk   (clk),
      .res   (res),
      .clr   (state_q != S_RUN),
      .adv   (beat_acc),
      .pixel (cnt_pixel),
      .last  (cnt_last)
   );

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      pass_d      = pass_q;
      bld_wr_en_d = 1'b0;
      bld_data_d  = bld_data_q;
      bld_pixel_d = bld_pixel_q;

      case (state_q)
         S_IDLE: begin
            pass_d = PASS_COARSE;
            wait_d = '0;
            if (enable) begin
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (wait_q == CLR_LAST) begin
               state_d = S_RUN;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         S_RUN: begin
            if (beat_acc) begin
               bld_wr_en_d = 1'b1;
               bld_data_d  = in_data;
               bld_pixel_d = cnt_pixel;
               if (cnt_last) begin
                  state_d = S_DRAIN;
                  wait_d  = '0;
               end
            end
         end
         S_DRAIN: begin
            if (wait_q == DRAIN_LAST) begin
               state_d = (pass_q == PASS_FINE) ? S_DONE : S_CALC;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         S_CALC: begin
            pass_d  = PASS_FINE;
            state_d = S_CLEAR;
            wait_d  = '0;
         end
         S_DONE: begin
            if (frame_ready) begin
               if (enable) begin
                  // Back-to-back frame skips IDLE and restarts the coarse pass.
                  state_d = S_CLEAR;
                  pass_d  = PASS_COARSE;
                  wait_d  = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            wait_d  = '0;
            pass_d  = PASS_COARSE;
         end
      endcase

      // Phase strobes are registered from the next state so they line up
      // exactly with the cycles spent in that state.
      bld_clear_d   = (state_d == S_CLEAR);
      bld_calc_d    = (state_d == S_CALC);
      frame_valid_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q       <= S_IDLE;
         wait_q        <= '0;
         pass_q        <= PASS_COARSE;
         bld_wr_en_q   <= 1'b0;
         bld_data_q    <= '0;
         bld_pixel_q   <= '0;
         bld_clear_q   <= 1'b0;
         bld_calc_q    <= 1'b0;
         frame_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         pass_q        <= pass_d;
         bld_wr_en_q   <= bld_wr_en_d;
         bld_data_q    <= bld_data_d;
         bld_pixel_q   <= bld_pixel_d;
         bld_clear_q   <= bld_clear_d;
         bld_calc_q    <= bld_calc_d;
         frame_valid_q <= frame_valid_d;
      end
   end

   assign in_ready    = (state_q == S_RUN);
   assign busy        = (state_q != S_IDLE);
   assign bld_wr_en   = bld_wr_en_q;
   assign bld_data    = bld_data_q;
   assign bld_pixel   = bld_pixel_q;
   assign bld_pass    = pass_q;
   assign bld_clear   = bld_clear_q;
   assign bld_calc    = bld_calc_q;
   assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_sifh_frame_sequencer.sv
// tb_sifh_frame_sequencer: directed bench for the SiFH frame sequencer.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_sifh_frame_sequencer;

   logic       clk = 1'b0;
   logic       res;
   logic       enable;
   logic       in_valid;
   logic [9:0] in_data;
   logic       in_ready;
   logic       bld_wr_en;
   logic [9:0] bld_data;
   logic [1:0] bld_pixel;
   logic       bld_pass;
   logic       bld_clear;
   logic       bld_calc;
   logic       frame_valid;
   logic       frame_ready;
   logic       busy;

   // Single-beat configuration (DATA_NUM = PIXEL_NUM = ACQ_NUM = 1).
   logic       m_enable;
   logic       m_in_valid;
   logic [9:0] m_in_data;
   logic       m_in_ready;
   logic       m_bld_wr_en;
   logic [9:0] m_bld_data;
   logic [0:0] m_bld_pixel;
   logic       m_bld_pass;
   logic       m_bld_clear;
   logic       m_bld_calc;
   logic       m_frame_valid;
   logic       m_frame_ready;
   logic       m_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sifh_frame_sequencer u_dut (
      .clk         (clk),
      .res         (res),
      .enable      (enable),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .bld_wr_en   (bld_wr_en),
      .bld_data    (bld_data),
      .bld_pixel   (bld_pixel),
      .bld_pass    (bld_pass),
      .bld_clear   (bld_clear),
      .bld_calc    (bld_calc),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .busy        (busy)
   );

   sifh_frame_sequencer #(
      .DATA_NUM  (1),
      .PIXEL_NUM (1),
      .ACQ_NUM   (1)
   ) u_dut_min (
      .clk         (clk),
      .res         (res),
      .enable      (m_enable),
      .in_valid    (m_in_valid),
      .in_data     (m_in_data),
      .in_ready    (m_in_ready),
      .bld_wr_en   (m_bld_wr_en),
      .bld_data    (m_bld_data),
      .bld_pixel   (m_bld_pixel),
      .bld_pass    (m_bld_pass),
      .bld_clear   (m_bld_clear),
      .bld_calc    (m_bld_calc),
      .frame_valid (m_frame_valid),
      .frame_ready (m_frame_ready),
      .busy        (m_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven and
   // outputs sampled here, 1 time unit clear of the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Feed up to n_beats timestamps starting in a RUN cycle, checking each
   // registered write beat one cycle after it is accepted.
   task automatic run_pass(input logic exp_pass, input bit gaps, input bit tog,
                           input int n_beats, input int data_base);
      int n;
      int budget;
      logic v;
      logic [9:0] d;
      n = 0;
      budget = 0;
      while (n < n_beats && budget < 400) begin
         chk("run_in_ready", {31'b0, in_ready}, 32'd1);
         v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
         d = 10'(data_base + n * 37);
         in_valid = v;
         in_data  = d;
         if (tog) enable = ~enable;
         step();
         chk("run_wr_en", {31'b0, bld_wr_en}, {31'b0, v});
         if (v) begin
            chk("run_data", {22'b0, bld_data}, {22'b0, d});
            chk("run_pixel", {30'b0, bld_pixel}, 32'((n / 2) % 4));
            chk("run_pass", {31'b0, bld_pass}, {31'b0, exp_pass});
            n++;
         end
         budget++;
      end
      in_valid = 1'b0;
      chk("pass_beat_count", 32'(n), 32'(n_beats));
   endtask

   // Three drain cycles, one calc cycle, then four clear cycles of the fine pass.
   task automatic coarse_to_fine();
      for (int i = 0; i < 3; i++) begin
         chk("drain_rdy", {31'b0, in_ready}, 32'd0);
         chk("drain_calc", {31'b0, bld_calc}, 32'd0);
         chk("drain_clear", {31'b0, bld_clear}, 32'd0);
         step();
      end
      chk("calc_hi", {31'b0, bld_calc}, 32'd1);
      chk("calc_rdy", {31'b0, in_ready}, 32'd0);
      step();
      for (int i = 0; i < 4; i++) begin
         chk("fine_clear", {31'b0, bld_clear}, 32'd1);
         chk("fine_clear_calc", {31'b0, bld_calc}, 32'd0);
         chk("fine_clear_pass", {31'b0, bld_pass}, 32'd1);
         chk("fine_clear_rdy", {31'b0, in_ready}, 32'd0);
         step();
      end
   endtask

   initial begin
      res           = 1'b1;
      enable        = 1'b0;
      in_valid      = 1'b0;
      in_data       = '0;
      frame_ready   = 1'b0;
      m_enable      = 1'b0;
      m_in_valid    = 1'b0;
      m_in_data     = '0;
      m_frame_ready = 1'b0;

      // ---- reset state ----
      step();
      step();
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_wr_en", {31'b0, bld_wr_en}, 32'd0);
      chk("rst_clear", {31'b0, bld_clear}, 32'd0);
      chk("rst_frame_valid", {31'b0, frame_valid}, 32'd0);
      res = 1'b0;
      step();
      chk("idle_busy", {31'b0, busy}, 32'd0);

      // ---- frame 1: continuous input ----
      enable = 1'b1;
      step();                       // edge 0
      enable = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         chk("clear_hi", {31'b0, bld_clear}, 32'd1);
         chk("clear_rdy", {31'b0, in_ready}, 32'd0);
         chk("clear_busy", {31'b0, busy}, 32'd1);
         step();
      end
      chk("clear_done", {31'b0, bld_clear}, 32'd0);
      run_pass(1'b0, 1'b0, 1'b0, 24, 100);
      chk("rdy_after_coarse", {31'b0, in_ready}, 32'd0);
      coarse_to_fine();
      // Fine pass with enable toggling throughout RUN.
      run_pass(1'b1, 1'b0, 1'b1, 24, 7);
      enable = 1'b0;
      chk("rdy_after_fine", {31'b0, in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("fdrain_fv", {31'b0, frame_valid}, 32'd0);
         chk("fdrain_calc", {31'b0, bld_calc}, 32'd0);
         step();
      end
      // ---- DONE with consumer stalled ----
      for (int i = 0; i < 10; i++) begin
         chk("done_fv", {31'b0, frame_valid}, 32'd1);
         chk("done_rdy", {31'b0, in_ready}, 32'd0);
         chk("done_busy", {31'b0, busy}, 32'd1);
         step();
      end
      frame_ready = 1'b1;
      enable      = 1'b1;
      step();                       // handshake edge
      frame_ready = 1'b0;
      enable      = 1'b0;
      chk("b2b_fv_fall", {31'b0, frame_valid}, 32'd0);
      chk("b2b_clear", {31'b0, bld_clear}, 32'd1);
      chk("b2b_pass", {31'b0, bld_pass}, 32'd0);
      for (int i = 0; i < 4; i++) step();

      // ---- frame 2: random gaps, reset during fine beat 10 ----
      run_pass(1'b0, 1'b1, 1'b0, 24, 300);
      chk("rdy_after_coarse2", {31'b0, in_ready}, 32'd0);
      coarse_to_fine();
      run_pass(1'b1, 1'b1, 1'b0, 10, 500);
      in_valid = 1'b1;
      in_data  = 10'h3c5;
      res      = 1'b1;
      #1;
      chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("mid_rst_wr_en", {31'b0, bld_wr_en}, 32'd0);
      chk("mid_rst_data", {22'b0, bld_data}, 32'd0);
      chk("mid_rst_pixel", {30'b0, bld_pixel}, 32'd0);
      chk("mid_rst_pass", {31'b0, bld_pass}, 32'd0);
      chk("mid_rst_clear", {31'b0, bld_clear}, 32'd0);
      chk("mid_rst_calc", {31'b0, bld_calc}, 32'd0);
      chk("mid_rst_fv", {31'b0, frame_valid}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      in_valid = 1'b0;
      step();
      res = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("post_rst_busy", {31'b0, busy}, 32'd0);
         chk("post_rst_fv", {31'b0, frame_valid}, 32'd0);
      end
      enable = 1'b1;
      step();
      enable = 1'b0;
      chk("restart_clear", {31'b0, bld_clear}, 32'd1);
      chk("restart_busy", {31'b0, busy}, 32'd1);

      // ---- single-beat configuration ----
      m_enable = 1'b1;
      step();
      m_enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("m_clear", {31'b0, m_bld_clear}, 32'd1);
         step();
      end
      chk("m_rdy_coarse", {31'b0, m_in_ready}, 32'd1);
      m_in_valid = 1'b1;
      m_in_data  = 10'h2aa;
      step();
      m_in_valid = 1'b0;
      chk("m_wr_c", {31'b0, m_bld_wr_en}, 32'd1);
      chk("m_data_c", {22'b0, m_bld_data}, 32'h2aa);
      chk("m_pixel_c", {31'b0, m_bld_pixel}, 32'd0);
      chk("m_pass_c", {31'b0, m_bld_pass}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("m_drain_rdy", {31'b0, m_in_ready}, 32'd0);
         chk("m_drain_calc", {31'b0, m_bld_calc}, 32'd0);
         step();
      end
      chk("m_calc", {31'b0, m_bld_calc}, 32'd1);
      step();
      for (int i = 0; i < 4; i++) begin
         chk("m_fclear", {31'b0, m_bld_clear}, 32'd1);
         chk("m_fclear_pass", {31'b0, m_bld_pass}, 32'd1);
         step();
      end
      chk("m_rdy_fine", {31'b0, m_in_ready}, 32'd1);
      m_in_valid = 1'b1;
      m_in_data  = 10'h155;
      step();
      m_in_valid = 1'b0;
      chk("m_wr_f", {31'b0, m_bld_wr_en}, 32'd1);
      chk("m_data_f", {22'b0, m_bld_data}, 32'h155);
      chk("m_pass_f", {31'b0, m_bld_pass}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         chk("m_fdrain_fv", {31'b0, m_frame_valid}, 32'd0);
         chk("m_fdrain_calc", {31'b0, m_bld_calc}, 32'd0);
         step();
      end
      chk("m_done_fv", {31'b0, m_frame_valid}, 32'd1);
      m_frame_ready = 1'b1;
      step();
      m_frame_ready = 1'b0;
      chk("m_idle_fv", {31'b0, m_frame_valid}, 32'd0);
      chk("m_idle_busy", {31'b0, m_busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
